// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
//   N_REQ       : number of requesters
//   SEL_W       : width of the requester index / mux select
//   sel_t       : requester index type
//   arb_state_t : output-register state (IDLE = empty, HOLD = word pending)
package mux_arb_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic [0:0] {
      IDLE,
      HOLD
   } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin mux arbiter.
//   req       : per-requester request, held with its data until granted
//   in0..in3  : requester data words
//   gnt       : one-hot grant, combinational
//   select    : index of the requester whose word is in out
//   out       : registered selected word
//   out_valid : out/select hold a word not yet accepted
//   out_ready : consumer accepts out this cycle
// Modports: slave = arbiter side, master = requesters plus consumer.
interface mux_rr_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 4
);

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  gnt;
   logic [DATA_W-1:0] in0;
   logic [DATA_W-1:0] in1;
   logic [DATA_W-1:0] in2;
   logic [DATA_W-1:0] in3;
   logic [DATA_W-1:0] out;
   sel_t              select;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  req, in0, in1, in2, in3, out_ready,
      output gnt, select, out, out_valid
   );

   modport master (
      output req, in0, in1, in2, in3, out_ready,
      input  gnt, select, out, out_valid
   );

endinterface

// File: rtl/MUX2.sv
// Shared 4:1 data multiplexer.
//   sel      : input index
//   in0..in3 : data words
//   y        : selected word
module MUX2 #(
   parameter int unsigned DATA_W = 4
) (
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      unique case (sel)
         2'd0:    y = in0;
         2'd1:    y = in1;
         2'd2:    y = in2;
         default: y = in3;
      endcase
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr (mod N_REQ).
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   gnt   : one-hot winner (all zero when nobody requests)
//   idx   : encoded winner index (ptr when nobody requests)
//   found : some requester won
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  sel_t             ptr,
   output logic [N_REQ-1:0] gnt,
   output sel_t             idx,
   output logic             found
);

   sel_t cand;

   always_comb begin
      gnt   = '0;
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         // Modular index: the 2-bit add wraps 3 -> 0 naturally.
         cand = ptr + sel_t'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found) begin
         gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux between four requesters; the
// winning word is registered and held on a valid/ready output.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester/consumer bundle (slave modport)
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_rr_arbiter_if.slave       bus
);

   arb_state_t        state_q;
   sel_t              ptr_q;
   sel_t              sel_q;
   logic [DATA_W-1:0] out_q;

   logic              load;
   logic [N_REQ-1:0]  pick_gnt;
   sel_t              pick_idx;
   logic              pick_found;
   logic [DATA_W-1:0] mux_y;

   // The output register can take a new word when empty or being drained.
   assign load = (state_q == IDLE) || bus.out_ready;

   rr_pick u_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   MUX2 #(
      .DATA_W (DATA_W)
   ) u_mux (
      .sel (pick_idx),
      .in0 (bus.in0),
      .in1 (bus.in1),
      .in2 (bus.in2),
      .in3 (bus.in3),
      .y   (mux_y)
   );

   // rst_n gates gnt so no transfer is signalled while the register is held in reset.
   assign bus.gnt       = (rst_n && load) ? pick_gnt : '0;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out       = out_q;
   assign bus.select    = sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         out_q   <= '0;
      end else if (load) begin
         if (pick_found) begin
            state_q <= HOLD;
            out_q   <= mux_y;
            sel_q   <= pick_idx;
            ptr_q   <= pick_idx + sel_t'(1);
         end else begin
            // out/select keep their last word; only validity drops.
            state_q <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: table of {req, out_ready, gnt,
// next out_valid/out/select} vectors, a one-deep expected-output queue, and
// hand sequences for reset behaviour.
module tb_mux_rr_arbiter;
   import mux_arb_pkg::*;

   typedef struct packed {
      logic       valid;
      logic [3:0] data;
      logic [1:0] sel;
   } exp_t;

   typedef struct packed {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] gnt;
      exp_t       nxt;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   exp_t        sb[$];
   vec_t        vecs[$];

   mux_rr_arbiter_if #(.DATA_W(4)) bus ();

   mux_rr_arbiter #(.DATA_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic rdy, input logic [3:0] g,
                               input logic vld, input logic [3:0] d, input logic [1:0] s);
      vec_t v;
      v.req       = r;
      v.rdy       = rdy;
      v.gnt       = g;
      v.nxt.valid = vld;
      v.nxt.data  = d;
      v.nxt.sel   = s;
      return v;
   endfunction

   // Drive on the falling edge, check gnt before the rising edge, check the
   // registered outputs just after it.
   task automatic apply(input vec_t v, input string name);
      exp_t want;
      exp_t got;
      @(negedge clk);
      bus.req       = v.req;
      bus.out_ready = v.rdy;
      #1;
      chk({name, " gnt"}, {4'b0, bus.gnt}, {4'b0, v.gnt});
      sb.push_back(v.nxt);
      @(posedge clk);
      #1;
      want = sb.pop_front();
      got.valid = bus.out_valid;
      got.data  = bus.out;
      got.sel   = bus.select;
      chk({name, " out"}, {1'b0, got}, {1'b0, want});
   endtask

   initial begin
      bus.in0       = 4'b1100;
      bus.in1       = 4'b1101;
      bus.in2       = 4'b1110;
      bus.in3       = 4'b1111;
      bus.req       = 4'b1111;
      bus.out_ready = 1'b0;

      // Reset state, with every requester asking.
      #3;
      chk("rst valid", {7'b0, bus.out_valid}, 8'd0);
      chk("rst out", {4'b0, bus.out}, 8'd0);
      chk("rst select", {6'b0, bus.select}, 8'd0);
      chk("rst gnt", {4'b0, bus.gnt}, 8'd0);

      @(negedge clk);
      bus.req = 4'b0000;
      rst_n   = 1'b1;

      //              req      rdy   gnt      vld   out      sel
      vecs.push_back(mk(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b1100, 2'd0));  // first grant
      vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'd0));  // drain
      vecs.push_back(mk(4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1111, 2'd3));  // ptr -> 0
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b1100, 2'd0));  // round robin
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0010, 1'b1, 4'b1101, 2'd1));
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0100, 1'b1, 4'b1110, 2'd2));
      vecs.push_back(mk(4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1111, 2'd3));
      vecs.push_back(mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b1100, 2'd0));
      vecs.push_back(mk(4'b0010, 1'b1, 4'b0010, 1'b1, 4'b1101, 2'd1));  // load 1101
      for (int i = 0; i < 5; i++) begin                                  // backpressure
         vecs.push_back(mk(4'b0101, 1'b0, 4'b0000, 1'b1, 4'b1101, 2'd1));
      end
      vecs.push_back(mk(4'b0101, 1'b1, 4'b0100, 1'b1, 4'b1110, 2'd2));  // release
      vecs.push_back(mk(4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1111, 2'd3));  // ptr=3
      vecs.push_back(mk(4'b1001, 1'b1, 4'b0001, 1'b1, 4'b1100, 2'd0));  // wrap
      vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'd0));  // idle drain
      vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1100, 2'd0));
      vecs.push_back(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 4'b1110, 2'd2));  // idle loads
      vecs.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b1, 4'b1110, 2'd2));  // hold, req moved

      foreach (vecs[i]) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset mid-HOLD: outputs clear before any clock edge.
      @(negedge clk);
      bus.req       = 4'b1111;
      bus.out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async valid", {7'b0, bus.out_valid}, 8'd0);
      chk("async out", {4'b0, bus.out}, 8'd0);
      chk("async select", {6'b0, bus.select}, 8'd0);
      chk("async gnt", {4'b0, bus.gnt}, 8'd0);

      @(negedge clk);
      bus.req = 4'b0000;
      rst_n   = 1'b1;

      // ptr was 3 before reset; a restored ptr=0 picks requester 1 here.
      apply(mk(4'b1010, 1'b1, 4'b0010, 1'b1, 4'b1101, 2'd1), "post-rst ptr");
      apply(mk(4'b1111, 1'b1, 4'b0100, 1'b1, 4'b1110, 2'd2), "post-rst rr");
      apply(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1110, 2'd2), "post-rst drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
